prog_loader: RTL
================

Name: prog_loader

Overview:
Streams symbolic instruction descriptors (kind plus fields) into the pipelined MIPS core's instruction memory. Each accepted descriptor is encoded into a 32-bit machine word and written at an incrementing word address. The block sits between the testbench or boot source and the imem write port, ahead of the instruction decoder. It produces exactly the opcode encodings that the decoder consumes.

Parameters:
ADDR_W, 8, imem word-address width
DEPTH, 256, max words written per load session (≤ 2**ADDR_W)
BASE, 0, first word address written after start

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: begin load session (honoured in IDLE/DONE only)
in_valid  in  1  descriptor valid
in_ready  out  1  descriptor accepted when in_valid & in_ready
in_last  in  1  marks final descriptor of session
in_kind  in  4  0 RTYPE, 1 LW, 2 SW, 3 BEQ, 4 BNE, 5 J, 6 ANDI, 7 ORI, 8 XORI, 9 ADDI; 10-15 invalid
in_rs  in  5  rs field
in_rt  in  5  rt field
in_rd  in  5  rd field (RTYPE)
in_shamt  in  5  shamt field (RTYPE)
in_funct  in  6  funct field (RTYPE)
in_imm  in  16  immediate / branch offset, packed verbatim
in_target  in  26  jump target (J)
imem_we  out  1  write strobe
imem_addr  out  ADDR_W  word address
imem_wdata  out  32  encoded instruction
busy  out  1  state == LOAD
done  out  1  state == DONE
count  out  ADDR_W+1  words written this session
err_kind  out  1  sticky: invalid kind seen this session
ovf  out  1  sticky: DEPTH reached without in_last

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; imem_addr = 0. imem_we drops immediately, mid-session included.
- FSM states: IDLE, LOAD, DONE.
  - IDLE/DONE + start → LOAD. On this transition: addr ← BASE, count ← 0, err_kind ← 0, ovf ← 0.
  - start in LOAD is ignored.
- in_ready = (state == LOAD) & (count < DEPTH).
- Accept with a valid kind: on the next edge imem_we = 1 for one cycle, imem_addr = current addr, imem_wdata = encoded word. Then addr += 1 (wraps modulo 2**ADDR_W) and count += 1. Write latency is 1 cycle. Back-to-back accepts give one write per cycle.
- Accept with an invalid kind: descriptor is consumed, no write, err_kind ← 1, addr and count unchanged.
- in_last on an accepted beat → DONE on the same edge, whether or not the kind is valid. The final write still occurs.
- count reaching DEPTH without in_last → DONE and ovf ← 1. If in_last arrives on the DEPTH-th word: DONE with ovf = 0.
- Encoding (op fields):
  - RTYPE = 000000, word {op, rs, rt, rd, shamt, funct}
  - LW = 100011, SW = 101011, BEQ = 000100, BNE = 000101, ANDI = 001100, ORI = 001101, XORI = 001110, ADDI = 001000, word {op, rs, rt, imm}
  - J = 000010, word {op, target}
  - Unused fields for a kind are ignored.
- imem_wdata and imem_addr hold their last values when imem_we = 0.

Optional Feature:
Macro PROG_LOADER_CHECKSUM_EN.
- Defined: adds output port checksum[31:0], cleared on start and XORed with every written word on its write cycle. Stable in DONE.
- Undefined: no port, no logic.

Decomposition:
- Shared package/include: opcode constants (same values the instruction decoder uses), in_kind encodings, and the 32-bit instruction field positions.
- One combinational sub-module, instr_encoder (kind + fields → word, plus a valid flag). The FSM, handshake and counters stay in prog_loader.

Test Plan:
- start, then LW rs=2 rt=3 imm=0x0010 with in_last → one cycle later imem_we = 1, addr 0, wdata 0x8C430010; done = 1, count = 1.
- RTYPE rs=2 rt=3 rd=1 shamt=0 funct=0x20, J target=0x10, BEQ rs=1 rt=2 imm=0xFFFF, ORI rs=0 rt=5 imm=0x00FF sent back-to-back → consecutive-cycle writes at addr 0..3: 0x00430820, 0x08000010, 0x1022FFFF, 0x340500FF.
- kind=12 between two valid LWs → two writes at addr 0 and 1 only; err_kind = 1; count = 2.
- DEPTH=4, six descriptors with no in_last → four writes; in_ready low after the 4th; ovf = 1; done = 1.
- rst_n low for one cycle while imem_we = 1 mid-session → imem_we and all flags 0 immediately; state IDLE; in_ready = 0 until start.
- With PROG_LOADER_CHECKSUM_EN, write 0x8C430010 and 0x00430820 → checksum = 0x8C000830.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: descriptor kinds, the opcode
// values the instruction decoder consumes, instruction field layouts and
// loader FSM states.
package prog_loader_pkg;

  // Descriptor kinds carried on in_kind; codes 10-15 are invalid.
  typedef enum logic [3:0] {
    KIND_RTYPE = 4'd0,
    KIND_LW    = 4'd1,
    KIND_SW    = 4'd2,
    KIND_BEQ   = 4'd3,
    KIND_BNE   = 4'd4,
    KIND_J     = 4'd5,
    KIND_ANDI  = 4'd6,
    KIND_ORI   = 4'd7,
    KIND_XORI  = 4'd8,
    KIND_ADDI  = 4'd9
  } kind_e;

  // Opcodes, identical to the decoder's table.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Field positions of the three instruction formats, MSB first.
  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } r_fmt_t;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
  } i_fmt_t;

  typedef struct packed {
    logic [5:0]  op;
    logic [25:0] target;
  } j_fmt_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/prog_loader_encoder.sv
// Combinational instruction encoder: descriptor kind plus fields to a
// 32-bit machine word, with a flag telling whether the kind is legal.
module instr_encoder
  import prog_loader_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        valid
);

  logic [5:0] op;
  logic       is_r;
  logic       is_j;

  // Select opcode and format from the kind, then pack the matching layout.
  always_comb begin
    op    = OP_RTYPE;
    is_r  = 1'b0;
    is_j  = 1'b0;
    valid = 1'b1;
    word  = '0;
    case (kind)
      KIND_RTYPE: begin op = OP_RTYPE; is_r = 1'b1; end
      KIND_LW:    op = OP_LW;
      KIND_SW:    op = OP_SW;
      KIND_BEQ:   op = OP_BEQ;
      KIND_BNE:   op = OP_BNE;
      KIND_J:     begin op = OP_J; is_j = 1'b1; end
      KIND_ANDI:  op = OP_ANDI;
      KIND_ORI:   op = OP_ORI;
      KIND_XORI:  op = OP_XORI;
      KIND_ADDI:  op = OP_ADDI;
      default:    valid = 1'b0;
    endcase
    if (!valid)
      word = '0;
    else if (is_r)
      word = r_fmt_t'{op: op, rs: rs, rt: rt, rd: rd, shamt: shamt, funct: funct};
    else if (is_j)
      word = j_fmt_t'{op: op, target: target};
    else
      word = i_fmt_t'{op: op, rs: rs, rt: rt, imm: imm};
  end

endmodule

// File: rtl/prog_loader.sv
// Program loader: accepts instruction descriptors over a valid/ready
// handshake, encodes them and writes them to consecutive imem words.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN adds a running XOR
// checksum output of all words written in the current session.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err_kind,
  output logic              ovf
`ifdef PROG_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       enc_word;
  logic              enc_valid;
  logic              accept;
  logic              start_go;
  logic              last_slot;

  instr_encoder u_enc (
    .kind   (in_kind),
    .rs     (in_rs),
    .rt     (in_rt),
    .rd     (in_rd),
    .shamt  (in_shamt),
    .funct  (in_funct),
    .imm    (in_imm),
    .target (in_target),
    .word   (enc_word),
    .valid  (enc_valid)
  );

  assign in_ready  = (state_q == ST_LOAD) && (count < DEPTH_C);
  assign accept    = in_valid && in_ready;
  assign start_go  = start && (state_q != ST_LOAD);
  assign last_slot = (count == DEPTH_C - 1'b1);
  assign busy      = (state_q == ST_LOAD);
  assign done      = (state_q == ST_DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: a session ends on in_last or when the final slot is written.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_LOAD;
      ST_LOAD: if (accept && (in_last || (enc_valid && last_slot))) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Write port, address/count tracking and sticky session flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      addr_q     <= '0;
      count      <= '0;
      err_kind   <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (start_go) begin
        addr_q   <= BASE_C;
        count    <= '0;
        err_kind <= 1'b0;
        ovf      <= 1'b0;
      end else if (accept) begin
        if (enc_valid) begin
          imem_we    <= 1'b1;
          imem_addr  <= addr_q;
          imem_wdata <= enc_word;
          addr_q     <= addr_q + 1'b1;
          count      <= count + 1'b1;
          if (!in_last && last_slot) ovf <= 1'b1;
        end else begin
          err_kind <= 1'b1;
        end
      end
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  // Running XOR of every word written since the last start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   checksum <= '0;
    else if (start_go)            checksum <= '0;
    else if (accept && enc_valid) checksum <= checksum ^ enc_word;
  end
`endif

endmodule
